// File: rtl/nibble_mult_seq_pkg.sv
// Shared constants for the nibble-serial multiplier: FSM encoding and nibble width.
package nibble_mult_seq_pkg;

  localparam int unsigned NIB_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/array_mult_structural.sv
// 4x4 unsigned array multiplier: AND-gated partial-product rows summed by
// ripple full-adder rows.
module array_mult_structural (
  input  logic [3:0] i_m,
  input  logic [3:0] i_q,
  output logic [7:0] o_pp
);

  logic [7:0] w_acc;
  logic [7:0] w_row;
  logic       w_c;
  logic       w_s;

  always_comb begin
    w_acc = {4'b0000, i_m & {4{i_q[0]}}};
    w_row = 8'h00;
    w_c   = 1'b0;
    w_s   = 1'b0;
    for (int k = 1; k < 4; k++) begin
      w_row = {4'b0000, i_m & {4{i_q[k]}}} << k;
      w_c   = 1'b0;
      for (int n = 0; n < 8; n++) begin
        w_s      = w_acc[n] ^ w_row[n] ^ w_c;
        w_c      = (w_acc[n] & w_row[n]) | (w_c & (w_acc[n] ^ w_row[n]));
        w_acc[n] = w_s;
      end
    end
    o_pp = w_acc;
  end

endmodule

// File: rtl/nibble_mult_seq.sv
// WIDTH x WIDTH unsigned multiplier that reuses one 4x4 array multiplier,
// accumulating one shifted nibble-pair product per cycle.
module nibble_mult_seq
  import nibble_mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned NIB = WIDTH / NIB_W;
  localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned PW  = 2 * WIDTH;

  if ((WIDTH % NIB_W) != 0 || WIDTH < 4 || WIDTH > 16) begin : g_bad_width
    $error("nibble_mult_seq: WIDTH must be a multiple of 4 in 4..16");
  end

  logic [1:0]       r_state;
  logic [IW-1:0]    r_i;
  logic [IW-1:0]    r_j;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_product;

  logic [3:0]       w_m;
  logic [3:0]       w_q;
  logic [7:0]       w_pp;
  int unsigned      w_shamt;
  logic [PW-1:0]    w_acc_next;
  logic             w_last_j;
  logic             w_last;

  always_comb begin
    w_m        = NIB_W'(r_a >> (NIB_W * 32'(r_i)));
    w_q        = NIB_W'(r_b >> (NIB_W * 32'(r_j)));
    w_shamt    = NIB_W * (32'(r_i) + 32'(r_j));
    w_acc_next = r_acc + (PW'(w_pp) << w_shamt);
    w_last_j   = (r_j == IW'(NIB - 1));
    w_last     = w_last_j && (r_i == IW'(NIB - 1));
  end

  array_mult_structural u_mult (
    .i_m  (w_m),
    .i_q  (w_q),
    .o_pp (w_pp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_i       <= '0;
      r_j       <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          if (w_last) begin
            r_product <= w_acc_next;
            r_state   <= DONE;
          end else if (w_last_j) begin
            r_j <= '0;
            r_i <= r_i + IW'(1);
          end else begin
            r_j <= r_j + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshake outputs come from state only, never from in_valid/out_ready.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN) || (r_state == DONE);
  assign product   = r_product;

endmodule

// File: tb/tb_nibble_mult_seq.sv
// Bench for nibble_mult_seq at WIDTH 4, 8 and 16 against a cycle-count model.
module tb_nibble_mult_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]       in_valid;
  logic [2:0]       in_ready;
  logic [2:0]       out_valid;
  logic [2:0]       out_ready;
  logic [2:0]       busy;
  logic [2:0][15:0] a_v;
  logic [2:0][15:0] b_v;
  logic [7:0]       p4;
  logic [15:0]      p8;
  logic [31:0]      p16;
  logic [2:0][31:0] prod;

  always_comb begin
    prod[0] = {24'h0, p4};
    prod[1] = {16'h0, p8};
    prod[2] = p16;
  end

  nibble_mult_seq #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_v[0][3:0]), .b(b_v[0][3:0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .product(p4), .busy(busy[0])
  );
  nibble_mult_seq #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .product(p8), .busy(busy[1])
  );
  nibble_mult_seq #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_v[2]), .b(b_v[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .product(p16), .busy(busy[2])
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int steps_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 16;
  endfunction

  function automatic logic [15:0] mask_of(input int k);
    return (k == 0) ? 16'h000F : (k == 1) ? 16'h00FF : 16'hFFFF;
  endfunction

  // Reference: an accepted pair yields a*b exactly STEPS edges later, held until taken.
  logic [2:0]  m_busy;
  logic [2:0]  m_ov;
  int          m_cnt  [3];
  logic [31:0] m_exp  [3];
  logic [31:0] m_prod [3];
  int          m_done [3] = '{0, 0, 0};

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_busy[k] <= 1'b0;
        m_ov[k]   <= 1'b0;
        m_cnt[k]  <= 0;
        m_prod[k] <= 32'h0;
      end else if (!m_busy[k]) begin
        if (in_valid[k]) begin
          m_busy[k] <= 1'b1;
          m_cnt[k]  <= steps_of(k);
          m_exp[k]  <= 32'(a_v[k] & mask_of(k)) * 32'(b_v[k] & mask_of(k));
        end
      end else if (!m_ov[k]) begin
        m_cnt[k] <= m_cnt[k] - 1;
        if (m_cnt[k] == 1) begin
          m_ov[k]   <= 1'b1;
          m_prod[k] <= m_exp[k];
        end
      end else if (out_ready[k]) begin
        m_ov[k]   <= 1'b0;
        m_busy[k] <= 1'b0;
        m_done[k] <= m_done[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check("model_in_ready", 32'(in_ready[k]), 32'(!m_busy[k]));
        check("model_out_valid", 32'(out_valid[k]), 32'(m_ov[k]));
        check("model_busy", 32'(busy[k]), 32'(m_busy[k]));
        check("model_product", prod[k], m_prod[k]);
      end
    end
  end

  task automatic run_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                        input int hold, input bit churn, input int exp_lat,
                        input logic [31:0] exp_p);
    int lat;
    @(posedge clk); #1;
    check("pre_accept_in_ready", 32'(in_ready[k]), 32'd1);
    a_v[k] = av;
    b_v[k] = bv;
    in_valid[k] = 1'b1;
    out_ready[k] = (hold == 0);
    @(posedge clk); #1;
    in_valid[k] = churn;
    lat = 0;
    while (!out_valid[k] && lat < 40) begin
      if (churn) begin
        a_v[k] = 16'($urandom);
        b_v[k] = 16'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("product", prod[k], exp_p);
    for (int h = 0; h < hold; h++) begin
      check("held_out_valid", 32'(out_valid[k]), 32'd1);
      check("held_in_ready", 32'(in_ready[k]), 32'd0);
      check("held_product", prod[k], exp_p);
      @(posedge clk); #1;
    end
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    check("post_hs_out_valid", 32'(out_valid[k]), 32'd0);
    check("post_hs_in_ready", 32'(in_ready[k]), 32'd1);
  endtask

  initial begin
    int start_done [3];
    bit all_done;
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = '0;
    a_v = '0;
    b_v = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("reset_in_ready", 32'(in_ready[k]), 32'd1);
      check("reset_out_valid", 32'(out_valid[k]), 32'd0);
      check("reset_busy", 32'(busy[k]), 32'd0);
      check("reset_product", prod[k], 32'h0);
    end
    rst_n = 1'b1;
    chk_en = 1'b1;

    run_op(1, 16'h12, 16'h34, 0, 1'b0, 4, 32'h03A8);
    run_op(1, 16'hFF, 16'hFF, 0, 1'b0, 4, 32'hFE01);
    run_op(1, 16'h00, 16'hAB, 0, 1'b0, 4, 32'h0000);
    run_op(1, 16'h0F, 16'h10, 6, 1'b0, 4, 32'h00F0);
    run_op(1, 16'hC3, 16'h5A, 2, 1'b1, 4, 32'h448E);
    run_op(1, 16'h21, 16'h07, 0, 1'b0, 4, 32'h00E7);
    run_op(0, 16'h0F, 16'h0F, 0, 1'b0, 1, 32'h00E1);
    run_op(2, 16'hFFFF, 16'hFFFF, 0, 1'b0, 16, 32'hFFFE0001);

    // Abandon an operation with reset on its second RUN cycle.
    @(posedge clk); #1;
    a_v[1] = 16'h55;
    b_v[1] = 16'h33;
    in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_out_valid", 32'(out_valid[1]), 32'd0);
    check("rst_mid_product", prod[1], 32'h0);
    check("rst_mid_in_ready", 32'(in_ready[1]), 32'd1);
    check("rst_mid_busy", 32'(busy[1]), 32'd0);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("rst_mid_no_stray", 32'(out_valid[1]), 32'd0);
    end

    for (int k = 0; k < 3; k++) start_done[k] = m_done[k];
    all_done = 1'b0;
    for (int cyc = 0; cyc < 40000 && !all_done; cyc++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        out_ready[k] = ($urandom_range(0, 3) != 0);
        a_v[k] = 16'($urandom);
        b_v[k] = 16'($urandom);
      end
      all_done = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (m_done[k] - start_done[k] < 1000) all_done = 1'b0;
      end
    end
    in_valid = '0;
    check("random_pairs_completed", 32'(all_done), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
